prio_arb_rr: RTL and testbench
==============================

# prio_arb_rr

Parametrised registered arbiter, successor to the fixed-priority encoder. Selects one of `N` requesters per grant in either fixed-priority mode (highest index wins) or round-robin mode, and holds the grant under a valid/ready handshake until the consumer accepts it. It sits between a bank of request lines and a single shared downstream resource, such as a bus port or a FIFO write side.

## Interface
- `N`, default 8: number of requesters; legal range 2..256; need not be a power of two.
- `W`, default `$clog2(N)`: index width; derived, not overridden.

- `clk`  in  1: clock; all state updates on the rising edge.
- `clr_n`  in  1: asynchronous, active-low reset.
- `req`  in  N: request vector; bit i = requester i wants the resource; sampled only at arbitration edges.
- `mode`  in  1: 0 = fixed priority (index N-1 highest), 1 = round-robin; sampled only at arbitration edges.
- `gnt_ready`  in  1: consumer accepts the current grant this cycle.
- `gnt_valid`  out  1: a grant is being presented.
- `gnt_idx`  out  W: index of the granted requester.
- `gnt_onehot`  out  N: one-hot form of `gnt_idx`; all-zero when `gnt_valid`=0.

## Operation
- Two states:
  - IDLE: `gnt_valid`=0.
  - GRANT: `gnt_valid`=1.
- Internal `ptr` (W bits) holds the last accepted index.
- An arbitration edge is any rising edge in IDLE, and any rising edge in GRANT with `gnt_ready`=1.
- At an arbitration edge:
  - If `req`≠0, a winner is selected and loaded into `gnt_idx`/`gnt_onehot`, and the state becomes GRANT.
  - Otherwise the state becomes IDLE, `gnt_onehot`=0, and `gnt_idx` keeps its old value.
- Fixed mode: the winner is the highest set index of `req`. `ptr` is ignored.
- Round-robin mode:
  - The search order is ptr-1, ptr-2, …, 0, N-1, …, ptr (descending, wrapping modulo N).
  - The winner is the first set bit in that order.
  - The last-accepted index has the lowest priority but is still grantable if it is the only request.
- Handshake completion (GRANT and `gnt_ready`=1): `ptr` ← current `gnt_idx`, in both modes.
  - The new winner chosen at the same edge uses the updated `ptr`, i.e. the just-accepted index.
  - This gives back-to-back grants with no idle cycle.
- While GRANT and `gnt_ready`=0:
  - `gnt_idx`, `gnt_onehot` and `ptr` are frozen.
  - Changes on `req` and `mode` are ignored, including deassertion of the granted bit.
- `gnt_ready` while IDLE has no effect.
- Non-power-of-two N:
  - The wrap goes from index 0 to N-1.
  - Index values ≥ N never appear on `gnt_idx`.
- Reset (`clr_n`=0, asynchronous, at any time including mid-grant):
  - `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0, `ptr`=0, state IDLE.
  - Reset aborts any pending grant; no handshake is implied.
  - With `ptr`=0, the first round-robin search starts at N-1, matching fixed priority.

## Timing
- Latency: `req` sampled at edge k → `gnt_valid`/`gnt_idx` valid after edge k; combinational path from `req` to outputs is none.
- Throughput: one accepted grant per cycle when `gnt_ready` is held at 1 and `req`≠0.
- All outputs are registered. `gnt_onehot` and `gnt_idx` always agree.
- Reset deassertion: the first arbitration occurs on the first rising edge with `clr_n`=1.

## Test plan
- **Reset:**
  - Stimulus: assert `clr_n`=0 asynchronously mid-cycle while GRANT with `gnt_idx`=5.
  - Required: outputs go to 0/0/0 immediately with no clock.
  - After release with `mode`=1, `req`=8'hFF, `gnt_ready`=1: first grant is 7.
- **Fixed priority:**
  - Stimulus: N=8, `mode`=0, `req`=8'b1010_0100, `gnt_ready`=1.
  - Required: `gnt_idx`=7 on every cycle; `gnt_onehot`=8'h80.
  - Then `req`=8'b0000_0100: next grant 2.
- **Round-robin sweep:**
  - Stimulus: `mode`=1, `req`=8'hFF, `gnt_ready`=1 for 10 cycles.
  - Required: `gnt_idx` sequence 7,6,5,4,3,2,1,0,7,6 with `gnt_valid` continuously 1.
- **Hold under backpressure:**
  - Stimulus: grant 6 presented with `gnt_ready`=0 for 4 cycles, while `req` changes 8'h40→8'h01→8'h00 and `mode` toggles.
  - Required: `gnt_idx`=6 and `gnt_valid`=1 throughout.
  - Then `gnt_ready`=1 with `req`=8'h00 → IDLE next cycle, `gnt_onehot`=0.
- **Lone and sparse requests, round-robin:**
  - Stimulus: after accepting 3, `req`=8'b0000_1000 → grant 3 again.
  - Then `req`=8'b0100_1001 after accepting 3 → grants 0, then 6, then 3.
- **Non-power-of-two:**
  - Stimulus: N=5 (W=3), `mode`=1, `req`=5'b11111, ready=1.
  - Required: sequence 4,3,2,1,0,4; `gnt_idx` never 5..7.

Source files
------------

// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter with fixed-priority or round-robin selection and a
// valid/ready grant handshake. All outputs come straight from flops.
module prio_arb_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           arb_edge;
  logic           accept;
  logic [W-1:0]   fixed_win;
  logic [W-1:0]   rr_win;
  logic [W-1:0]   win;
  int unsigned    cand;

  always_comb begin
    accept   = (state_q == StGrant) && gnt_ready;
    arb_edge = (state_q == StIdle) || gnt_ready;
    // The index accepted at this edge already counts as lowest priority.
    ptr_d    = accept ? idx_q : ptr_q;

    // Later hits overwrite earlier ones, so the last match is the winner.
    fixed_win = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i[W-1:0]]) fixed_win = i[W-1:0];
    end

    // Walk from lowest priority (ptr) up to highest (ptr-1), wrapping mod N.
    rr_win = '0;
    cand   = 0;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = int'(ptr_d) + N - k;
      if (cand >= N) cand = cand - N;
      if (req[cand[W-1:0]]) rr_win = cand[W-1:0];
    end

    win = mode ? rr_win : fixed_win;

    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (arb_edge) begin
      if (|req) begin
        state_d  = StGrant;
        idx_d    = win;
        onehot_d = {{(N-1){1'b0}}, 1'b1} << win;
      end else begin
        state_d  = StIdle;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_valid  = (state_q == StGrant);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed bench for prio_arb_rr: an 8-way and a 5-way instance share clock and reset.
module tb_prio_arb_rr;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;

  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0;
  logic       rdy8 = 1'b0;
  logic       v8;
  logic [2:0] idx8;
  logic [7:0] oh8;

  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       rdy5 = 1'b0;
  logic       v5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int tests_run = 0;
  int tests_fail = 0;

  always #5 clk = ~clk;

  prio_arb_rr #(.N(8)) dut8 (
    .clk        (clk),
    .clr_n      (clr_n),
    .req        (req8),
    .mode       (mode8),
    .gnt_ready  (rdy8),
    .gnt_valid  (v8),
    .gnt_idx    (idx8),
    .gnt_onehot (oh8)
  );

  prio_arb_rr #(.N(5)) dut5 (
    .clk        (clk),
    .clr_n      (clr_n),
    .req        (req5),
    .mode       (mode5),
    .gnt_ready  (rdy5),
    .gnt_valid  (v5),
    .gnt_idx    (idx5),
    .gnt_onehot (oh5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (v8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      tests_fail++;
      $display("FAIL reset_init: got v=%b idx=%0d oh=%h, expected v=0 idx=0 oh=00", v8, idx8, oh8);
    end
    mode8 = 1'b0; req8 = 8'h20; rdy8 = 1'b1;
    clr_n = 1'b1;
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd5 || oh8 !== 8'h20) begin
      tests_fail++;
      $display("FAIL reset_pregrant: got v=%b idx=%0d oh=%h, expected v=1 idx=5 oh=20", v8, idx8, oh8);
    end
    #2 clr_n = 1'b0;
    #1;
    tests_run++;
    if (v8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      tests_fail++;
      $display("FAIL reset_async: got v=%b idx=%0d oh=%h, expected v=0 idx=0 oh=00", v8, idx8, oh8);
    end
    mode8 = 1'b1; req8 = 8'hFF; rdy8 = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd7 || oh8 !== 8'h80) begin
      tests_fail++;
      $display("FAIL reset_first_rr: got v=%b idx=%0d oh=%h, expected v=1 idx=7 oh=80", v8, idx8, oh8);
    end
  endtask

  task automatic test_fixed();
    mode8 = 1'b0; req8 = 8'b1010_0100; rdy8 = 1'b1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (v8 !== 1'b1 || idx8 !== 3'd7 || oh8 !== 8'h80) begin
        tests_fail++;
        $display("FAIL fixed_high cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=7 oh=80",
                 c, v8, idx8, oh8);
      end
    end
    req8 = 8'b0000_0100;
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd2 || oh8 !== 8'h04) begin
      tests_fail++;
      $display("FAIL fixed_low: got v=%b idx=%0d oh=%h, expected v=1 idx=2 oh=04", v8, idx8, oh8);
    end
  endtask

  task automatic test_rr_sweep();
    logic [2:0] exp_seq [10];
    exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    mode8 = 1'b1; req8 = 8'hFF; rdy8 = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if (v8 !== 1'b1 || idx8 !== exp_seq[c] || oh8 !== (8'h01 << exp_seq[c])) begin
        tests_fail++;
        $display("FAIL rr_sweep cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=%0d",
                 c, v8, idx8, oh8, exp_seq[c]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] req_seq [4];
    req_seq = '{8'h40, 8'h01, 8'h00, 8'h00};
    mode8 = 1'b1; req8 = 8'h40; rdy8 = 1'b0;
    do_reset();
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd6 || oh8 !== 8'h40) begin
      tests_fail++;
      $display("FAIL hold_first: got v=%b idx=%0d oh=%h, expected v=1 idx=6 oh=40", v8, idx8, oh8);
    end
    for (int c = 0; c < 4; c++) begin
      req8 = req_seq[c];
      mode8 = ~mode8;
      step();
      tests_run++;
      if (v8 !== 1'b1 || idx8 !== 3'd6 || oh8 !== 8'h40) begin
        tests_fail++;
        $display("FAIL hold cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=6 oh=40",
                 c, v8, idx8, oh8);
      end
    end
    req8 = 8'h00; rdy8 = 1'b1;
    step();
    tests_run++;
    if (v8 !== 1'b0 || idx8 !== 3'd6 || oh8 !== 8'h00) begin
      tests_fail++;
      $display("FAIL hold_release: got v=%b idx=%0d oh=%h, expected v=0 idx=6 oh=00", v8, idx8, oh8);
    end
  endtask

  task automatic test_lone_sparse();
    logic [2:0] exp_seq [3];
    exp_seq = '{3'd0, 3'd6, 3'd3};
    mode8 = 1'b1; req8 = 8'b0000_1000; rdy8 = 1'b1;
    do_reset();
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd3) begin
      tests_fail++;
      $display("FAIL lone_first: got v=%b idx=%0d, expected v=1 idx=3", v8, idx8);
    end
    step();
    tests_run++;
    if (v8 !== 1'b1 || idx8 !== 3'd3 || oh8 !== 8'h08) begin
      tests_fail++;
      $display("FAIL lone_again: got v=%b idx=%0d oh=%h, expected v=1 idx=3 oh=08", v8, idx8, oh8);
    end
    req8 = 8'b0100_1001;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (v8 !== 1'b1 || idx8 !== exp_seq[c]) begin
        tests_fail++;
        $display("FAIL sparse cyc%0d: got v=%b idx=%0d, expected v=1 idx=%0d",
                 c, v8, idx8, exp_seq[c]);
      end
    end
  endtask

  task automatic test_npot();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    mode5 = 1'b1; req5 = 5'b11111; rdy5 = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++;
      if (v5 !== 1'b1 || idx5 !== exp_seq[c] || idx5 > 3'd4 || oh5 !== (5'h01 << exp_seq[c])) begin
        tests_fail++;
        $display("FAIL npot cyc%0d: got v=%b idx=%0d oh=%b, expected v=1 idx=%0d",
                 c, v5, idx5, oh5, exp_seq[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_hold();
    test_lone_sparse();
    test_npot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
